// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: checks queued fetch predictions against execute outcomes,
// maintains the 2-bit BHT read by fetch, and raises a timed flush with a redirect on mispredict.
module branch_resolve_unit #(
    parameter int ADDR_W       = 5,
    parameter int IDX_W        = 3,
    parameter int QDEPTH       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         lookup_pc,
    output logic                      lookup_taken,
    input  logic                      pred_valid,
    output logic                      pred_ready,
    input  logic [ADDR_W-1:0]         pred_pc,
    input  logic                      pred_taken,
    input  logic [ADDR_W-1:0]         pred_target,
    input  logic                      res_valid,
    input  logic                      res_taken,
    input  logic [ADDR_W-1:0]         res_target,
    input  logic [ADDR_W-1:0]         res_fallthrough,
    output logic                      flush,
    output logic [ADDR_W-1:0]         redirect_pc,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic [7:0]                mispredict_cnt,
    output logic                      orphan_err
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FLC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(QDEPTH);
    localparam logic [FLC_W-1:0] FLC_LOAD = FLC_W'(FLUSH_CYCLES - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [FLC_W-1:0]       flc_q, flc_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      redirect_q, redirect_d;
    logic [7:0]             mcnt_q, mcnt_d;
    logic                   orphan_q, orphan_d;

    logic [IDX_W-1:0]       q_idx_q   [QDEPTH];
    logic                   q_taken_q [QDEPTH];
    logic [ADDR_W-1:0]      q_tgt_q   [QDEPTH];
    logic [1:0]             bht_q     [2**IDX_W];

    logic run, do_res, do_enq, orphan, mispredict;
    logic unused_pc_bits;

    function automatic logic [1:0] bht_next(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Only the BHT index bits of a PC are ever needed.
    assign unused_pc_bits = ^{lookup_pc[ADDR_W-1:IDX_W], pred_pc[ADDR_W-1:IDX_W]};

    assign run        = (state_q == RUN);
    assign do_res     = run && res_valid && (cnt_q != '0);
    assign orphan     = run && res_valid && (cnt_q == '0);
    assign pred_ready = run && ((cnt_q < FULL) || do_res);
    assign do_enq     = pred_valid && pred_ready;
    assign mispredict = do_res && ((q_taken_q[head_q] != res_taken) ||
                                   (res_taken && (q_tgt_q[head_q] != res_target)));

    assign lookup_taken   = bht_q[lookup_pc[IDX_W-1:0]][1];
    assign flush          = (state_q == FLUSH);
    assign redirect_pc    = redirect_q;
    assign q_count        = cnt_q;
    assign mispredict_cnt = mcnt_q;
    assign orphan_err     = orphan_q;

    always_comb begin
        state_d    = state_q;
        flc_d      = flc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        redirect_d = redirect_q;
        mcnt_d     = mcnt_q;
        orphan_d   = orphan_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    // Clearing the queue also drops any enqueue made this cycle.
                    state_d    = FLUSH;
                    flc_d      = FLC_LOAD;
                    head_d     = '0;
                    tail_d     = '0;
                    cnt_d      = '0;
                    redirect_d = res_taken ? res_target : res_fallthrough;
                    mcnt_d     = sat_inc8(mcnt_q);
                end else begin
                    if (do_enq) tail_d = tail_q + PTR_W'(1);
                    if (do_res) head_d = head_q + PTR_W'(1);
                    cnt_d = cnt_q + CNT_W'(do_enq) - CNT_W'(do_res);
                end
                if (orphan) orphan_d = 1'b1;
            end
            FLUSH: begin
                if (flc_q == '0) state_d = RUN;
                else             flc_d   = flc_q - FLC_W'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            flc_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            redirect_q <= '0;
            mcnt_q     <= '0;
            orphan_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            flc_q      <= flc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            mcnt_q     <= mcnt_d;
            orphan_q   <= orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            q_idx_q[tail_q]   <= pred_pc[IDX_W-1:0];
            q_taken_q[tail_q] <= pred_taken;
            q_tgt_q[tail_q]   <= pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2**IDX_W; i++) bht_q[i] <= 2'b01;
        end else if (do_res) begin
            bht_q[q_idx_q[head_q]] <= bht_next(bht_q[q_idx_q[head_q]], res_taken);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations checked with immediate assertions.
module tb_branch_resolve_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] lookup_pc;
    logic       lookup_taken;
    logic       pred_valid;
    logic       pred_ready;
    logic [4:0] pred_pc;
    logic       pred_taken;
    logic [4:0] pred_target;
    logic       res_valid;
    logic       res_taken;
    logic [4:0] res_target;
    logic [4:0] res_fallthrough;
    logic       flush;
    logic [4:0] redirect_pc;
    logic [2:0] q_count;
    logic [7:0] mispredict_cnt;
    logic       orphan_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc),
        .lookup_taken   (lookup_taken),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_fallthrough(res_fallthrough),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .q_count        (q_count),
        .mispredict_cnt (mispredict_cnt),
        .orphan_err     (orphan_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] pc, input logic tk, input logic [4:0] tg);
        pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tg;
        step();
        pred_valid = 1'b0;
    endtask

    task automatic res(input logic tk, input logic [4:0] tg, input logic [4:0] ft);
        res_valid = 1'b1; res_taken = tk; res_target = tg; res_fallthrough = ft;
        step();
        res_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [4:0] pc, input logic exp);
        lookup_pc = pc;
        #1;
        chk(tag, 32'(lookup_taken), 32'(exp));
    endtask

    initial begin
        reset = 1'b0; lookup_pc = 5'd0;
        pred_valid = 1'b0; pred_pc = 5'd0; pred_taken = 1'b0; pred_target = 5'd0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = 5'd0; res_fallthrough = 5'd0;
        step();
        step();
        reset = 1'b1;

        // Reset state
        look("rst_lookup3", 5'd3, 1'b0);
        chk("rst_qcount", 32'(q_count), 0);
        chk("rst_ready", 32'(pred_ready), 1);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_redirect", 32'(redirect_pc), 0);
        chk("rst_mcnt", 32'(mispredict_cnt), 0);
        chk("rst_orphan", 32'(orphan_err), 0);

        // Correct not-taken predictions drive BHT[4] 01 -> 00 -> 00
        enq(5'd4, 1'b0, 5'd9);
        chk("enq1_qcount", 32'(q_count), 1);
        res(1'b0, 5'd0, 5'd5);
        chk("nt1_flush", 32'(flush), 0);
        chk("nt1_qcount", 32'(q_count), 0);
        enq(5'd4, 1'b0, 5'd9);
        res(1'b0, 5'd0, 5'd5);
        chk("nt2_flush", 32'(flush), 0);
        // 00 + taken = 01 (not taken), 01 + taken = 10 (taken)
        enq(5'd4, 1'b1, 5'd9);
        res(1'b1, 5'd9, 5'd5);
        chk("tk1_flush", 32'(flush), 0);
        look("bht4_sat_lo", 5'd4, 1'b0);
        enq(5'd4, 1'b1, 5'd9);
        res_valid = 1'b1; res_taken = 1'b1; res_target = 5'd9; res_fallthrough = 5'd5;
        #1;
        chk("bht4_no_bypass", 32'(lookup_taken), 0);
        step();
        res_valid = 1'b0;
        look("bht4_after_inc", 5'd4, 1'b1);
        chk("tk2_mcnt", 32'(mispredict_cnt), 0);

        // Direction mispredict: predicted not-taken, actually taken to 17
        enq(5'd2, 1'b0, 5'd0);
        res(1'b1, 5'd17, 5'd3);
        chk("mp1_flush", 32'(flush), 1);
        chk("mp1_redirect", 32'(redirect_pc), 17);
        chk("mp1_mcnt", 32'(mispredict_cnt), 1);
        chk("mp1_qcount", 32'(q_count), 0);
        chk("mp1_ready", 32'(pred_ready), 0);
        pred_valid = 1'b1; pred_pc = 5'd3; pred_taken = 1'b0; pred_target = 5'd0;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        chk("mp1_flush_c2", 32'(flush), 1);
        step();
        pred_valid = 1'b0; res_valid = 1'b0;
        chk("mp1_flush_end", 32'(flush), 0);
        chk("mp1_pred_ignored", 32'(q_count), 0);
        chk("mp1_res_ignored", 32'(orphan_err), 0);
        chk("mp1_redirect_hold", 32'(redirect_pc), 17);
        look("bht2_after_mp", 5'd2, 1'b1);

        // Target mispredict then untaken mispredict
        enq(5'd6, 1'b1, 5'd10);
        res(1'b1, 5'd12, 5'd7);
        chk("mp2_flush", 32'(flush), 1);
        chk("mp2_redirect", 32'(redirect_pc), 12);
        step();
        step();
        enq(5'd6, 1'b1, 5'd10);
        res(1'b0, 5'd0, 5'd7);
        chk("mp3_flush", 32'(flush), 1);
        chk("mp3_redirect", 32'(redirect_pc), 7);
        chk("mp3_mcnt", 32'(mispredict_cnt), 3);
        step();
        step();

        // Full queue, simultaneous enqueue/resolve, FIFO order
        enq(5'd1, 1'b0, 5'd0);
        enq(5'd3, 1'b0, 5'd0);
        enq(5'd5, 1'b0, 5'd0);
        enq(5'd7, 1'b0, 5'd0);
        chk("full_qcount", 32'(q_count), 4);
        chk("full_ready", 32'(pred_ready), 0);
        res_valid = 1'b1; res_taken = 1'b0; res_target = 5'd0; res_fallthrough = 5'd2;
        pred_valid = 1'b1; pred_pc = 5'd0; pred_taken = 1'b1; pred_target = 5'd20;
        #1;
        chk("full_ready_bypass", 32'(pred_ready), 1);
        step();
        res_valid = 1'b0; pred_valid = 1'b0;
        chk("swap_qcount", 32'(q_count), 4);
        chk("swap_flush", 32'(flush), 0);
        res(1'b0, 5'd0, 5'd4);
        chk("fifo1_flush", 32'(flush), 0);
        res(1'b0, 5'd0, 5'd6);
        chk("fifo2_flush", 32'(flush), 0);
        res(1'b0, 5'd0, 5'd8);
        chk("fifo3_flush", 32'(flush), 0);
        res(1'b1, 5'd20, 5'd1);
        chk("fifo4_flush", 32'(flush), 0);
        chk("fifo_qcount", 32'(q_count), 0);
        chk("fifo_mcnt", 32'(mispredict_cnt), 3);

        // Orphan resolve
        res(1'b0, 5'd0, 5'd0);
        chk("orphan_set", 32'(orphan_err), 1);
        chk("orphan_noflush", 32'(flush), 0);
        step();
        chk("orphan_sticky", 32'(orphan_err), 1);

        // Reset in the middle of a flush
        enq(5'd1, 1'b1, 5'd4);
        res(1'b0, 5'd0, 5'd2);
        chk("mp4_flush", 32'(flush), 1);
        chk("mp4_redirect", 32'(redirect_pc), 2);
        chk("mp4_mcnt", 32'(mispredict_cnt), 4);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst2_flush", 32'(flush), 0);
        chk("rst2_qcount", 32'(q_count), 0);
        chk("rst2_redirect", 32'(redirect_pc), 0);
        chk("rst2_mcnt", 32'(mispredict_cnt), 0);
        chk("rst2_orphan", 32'(orphan_err), 0);
        chk("rst2_ready", 32'(pred_ready), 1);
        for (int i = 0; i < 8; i++) look($sformatf("rst2_bht%0d", i), 5'(i), 1'b0);
        // BHT[1] was 00 before reset; from 01 one taken resolve reaches 10
        enq(5'd1, 1'b1, 5'd4);
        res(1'b1, 5'd4, 5'd2);
        chk("rst2_tk_flush", 32'(flush), 0);
        look("rst2_bht1_inc", 5'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution-side partner to the fetch-stage branch predictor.
- Holds an in-order queue of predictions issued at fetch and checks each one against the real outcome produced in execute (flag mux result and target).
- Owns the 2-bit saturating history table (BHT) that fetch reads. On a mispredict it raises a multi-cycle flush and supplies the corrected fetch address.

Parameters:
- ADDR_W, 5, instruction address width (matches the 5-bit PC used throughout the pipeline).
- IDX_W, 3, BHT index width; 2**IDX_W entries, indexed by pc[IDX_W-1:0].
- QDEPTH, 4, number of in-flight prediction queue entries; must be a power of 2.
- FLUSH_CYCLES, 2, number of cycles flush is held after a mispredict.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- lookup_pc  in  ADDR_W  fetch-stage PC used for the BHT lookup.
- lookup_taken  out  1  MSB of BHT[lookup_pc[IDX_W-1:0]]; combinational.
- pred_valid  in  1  fetch issued a branch prediction this cycle.
- pred_ready  out  1  high when the queue can accept a prediction.
- pred_pc  in  ADDR_W  PC of the predicted branch.
- pred_taken  in  1  predicted direction.
- pred_target  in  ADDR_W  predicted target address.
- res_valid  in  1  execute is resolving the oldest branch this cycle.
- res_taken  in  1  actual direction (output of the flag/funct3 mux).
- res_target  in  ADDR_W  actual taken target.
- res_fallthrough  in  ADDR_W  PC+1 of the branch.
- flush  out  1  clear younger pipeline stages and load redirect_pc.
- redirect_pc  out  ADDR_W  corrected fetch address.
- q_count  out  $clog2(QDEPTH)+1  current queue occupancy.
- mispredict_cnt  out  8  saturating count of mispredicts.
- orphan_err  out  1  sticky; set when res_valid arrives with an empty queue.

Behaviour:
- Reset values (on clk edge with reset==0):
  - Queue empty, state RUN.
  - flush=0, redirect_pc=0, mispredict_cnt=0, orphan_err=0.
  - Every BHT entry = 2'b01 (weakly not-taken).
- States:
  - RUN: normal operation.
  - FLUSH: counter flc loads FLUSH_CYCLES-1, decrements each cycle; state returns to RUN after flc reaches 0.
- pred_ready:
  - Asserted only when state==RUN and q_count<QDEPTH.
  - Exception: q_count==QDEPTH with a matching resolve this cycle still asserts pred_ready, so enqueue and dequeue can happen in the same cycle.
- Enqueue: pred_valid&&pred_ready pushes {pc, taken, target} at the tail; pointers wrap modulo QDEPTH.
- Resolve (res_valid with queue non-empty):
  - Pop the head entry.
  - mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
  - BHT[head.pc idx] updates every resolve: increment if res_taken, decrement otherwise; saturates at 2'b11 and 2'b00.
- On mispredict (registered, visible the cycle after the resolve):
  - flush=1, redirect_pc = res_taken ? res_target : res_fallthrough.
  - Queue cleared, which also discards any same-cycle enqueue.
  - mispredict_cnt increments, saturating at 255.
  - State goes to FLUSH.
  - flush stays high for exactly FLUSH_CYCLES cycles; redirect_pc holds its value until the next mispredict.
- In FLUSH: pred_valid is ignored; res_valid is ignored, with no BHT update and no orphan_err (those are squashed instructions).
- Correct prediction: entry popped, no flush, BHT still updated.
- res_valid with empty queue in RUN: orphan_err set (cleared only by reset); no BHT change, no flush.
- Lookup/update conflict: lookup_taken shows the pre-update value in the cycle the BHT write occurs (no bypass).
- Reset during FLUSH: reset wins; all state returns to reset values on that edge.

Test Plan:
- After reset, lookup_pc=5'd3 -> lookup_taken=0, q_count=0, pred_ready=1, flush=0.
- Enqueue {pc=4, taken=0, target=9}, then resolve res_taken=0 -> no flush, q_count returns to 0, BHT[4]=00; a second identical resolve keeps BHT[4]=00 (saturation).
- Enqueue {pc=2, taken=0}, resolve res_taken=1, res_target=17 -> flush=1 for 2 cycles starting the next cycle, redirect_pc=17, mispredict_cnt=1, queue empty; pred_valid during flush is ignored.
- Enqueue {pc=6, taken=1, target=10}, resolve res_taken=1, res_target=12 -> target mispredict, redirect_pc=12; an untaken mispredict with res_fallthrough=7 -> redirect_pc=7.
- Fill 4 entries -> pred_ready=0; assert res_valid (correct) with pred_valid in the same cycle -> q_count stays 4, FIFO order is preserved on the subsequent 4 resolves.
- res_valid with empty queue -> orphan_err=1 and stays 1; drive reset=0 mid-FLUSH -> flush=0 and all BHT entries=01 on the next edge.
